// File: rtl/ebc_pkg.sv
// rtl/ebc_pkg.sv - shared types and width helpers for the event readout arbiter
//
// Contents:
//   state_e     - readout FSM states (IDLE: choose a group, SERVE: drain locked group)
//   ga_w/pa_w   - group / pixel address widths
//   evt_word_t  - registered event word (address + timestamp) held in the output slot;
//                 fields are sized for the largest supported build and sliced by the top
package ebc_pkg;

  localparam int EBC_ADDR_MAX_W = 16;
  localparam int EBC_TS_MAX_W   = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  function automatic int ga_w(input int num_grp);
    return (num_grp > 1) ? $clog2(num_grp) : 1;
  endfunction

  function automatic int pa_w(input int grp_pix);
    return (grp_pix > 1) ? $clog2(grp_pix) : 1;
  endfunction

  typedef struct packed {
    logic [EBC_ADDR_MAX_W-1:0] addr;
    logic [EBC_TS_MAX_W-1:0]   ts;
  } evt_word_t;

endpackage

// File: rtl/event_readout_arbiter_rr_arbiter.sv
// rtl/event_readout_arbiter_rr_arbiter.sv - round-robin arbiter (module rr_arbiter)
//
// Ports:
//   req_i [N-1:0]  - request vector
//   ptr_i          - highest-priority index; search runs upward from here and wraps
//   gnt_o [N-1:0]  - one-hot grant (all zero when no request)
//   idx_o          - index of the granted request (0 when no request)
//   any_o          - at least one request present
// N must be a power of 2 so the pointer arithmetic wraps naturally.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    cand  = '0;
    found = 1'b0;
    idx_o = '0;
    gnt_o = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr_i + IW'(k);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    gnt_o[idx_o] = found;
    any_o        = found;
  end

endmodule

// File: rtl/event_readout_arbiter.sv
// rtl/event_readout_arbiter.sv - pixel event readout arbiter with group locking and bursts
//
// Optional feature macro: EVT_TIMESTAMP_EN (free-running timestamp captured per event;
// when undefined evt_ts_o is tied to 0 and no counter is built).
//
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   set_i        - per-pixel event pulses, bit g*GRP_PIX+p = group g pixel p
//   evt_valid_o  - output slot holds an event
//   evt_ready_i  - consumer accepts the event
//   evt_addr_o   - {group, pixel} of the event
//   evt_ts_o     - event timestamp
//   pend_o       - sticky pending latches
//   busy_o       - any pixel pending or an event in the slot
module event_readout_arbiter
  import ebc_pkg::*;
#(
  parameter int NUM_GRP   = 16,
  parameter int GRP_PIX   = 16,
  parameter int MAX_BURST = 4,
  parameter int TS_W      = 16
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_GRP*GRP_PIX-1:0]                set_i,
  output logic                                      evt_valid_o,
  input  logic                                      evt_ready_i,
  output logic [ga_w(NUM_GRP)+pa_w(GRP_PIX)-1:0]    evt_addr_o,
  output logic [TS_W-1:0]                           evt_ts_o,
  output logic [NUM_GRP*GRP_PIX-1:0]                pend_o,
  output logic                                      busy_o
);

  localparam int GA_W = ga_w(NUM_GRP);
  localparam int PA_W = pa_w(GRP_PIX);
  localparam int AW   = GA_W + PA_W;
  localparam int NPIX = NUM_GRP * GRP_PIX;
  localparam int BW   = $clog2(MAX_BURST + 1);

  state_e            state_q, state_d;
  logic [NPIX-1:0]   pend_q, pend_d;
  logic [GA_W-1:0]   lock_q, lock_d;
  logic [GA_W-1:0]   gptr_q, gptr_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [PA_W-1:0]   last_q, last_d;
  logic              valid_q, valid_d;
  evt_word_t         evt_q, evt_d;

  logic [TS_W-1:0]   ts_now;

  logic [NUM_GRP-1:0] grp_req;
  logic [NUM_GRP-1:0] grp_gnt_unused;
  logic [GA_W-1:0]    grp_idx;
  logic               grp_any;

  logic [GA_W-1:0]    sel_grp;
  logic [GRP_PIX-1:0] grp_pend;
  logic [PA_W-1:0]    pix_ptr;
  logic [GRP_PIX-1:0] pix_gnt;
  logic [PA_W-1:0]    pix_idx;
  logic               pix_any;

  logic               slot_free;
  logic               load;
  logic               rem;
  logic [BW-1:0]      burst_next;
  logic [NPIX-1:0]    clr_mask;
  logic               evt_unused;

  always_comb begin
    grp_req = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      grp_req[g] = |pend_q[g*GRP_PIX +: GRP_PIX];
    end
  end

  rr_arbiter #(.N(NUM_GRP)) u_grp_arb (
    .req_i (grp_req),
    .ptr_i (gptr_q),
    .gnt_o (grp_gnt_unused),
    .idx_o (grp_idx),
    .any_o (grp_any)
  );

  // IDLE scans from pixel 0 of the newly chosen group; SERVE continues above the
  // last served pixel so a continuously firing pixel cannot starve its neighbours.
  assign sel_grp  = (state_q == ST_SERVE) ? lock_q : grp_idx;
  assign grp_pend = pend_q[int'(sel_grp)*GRP_PIX +: GRP_PIX];
  assign pix_ptr  = (state_q == ST_SERVE) ? last_q + PA_W'(1) : '0;

  rr_arbiter #(.N(GRP_PIX)) u_pix_arb (
    .req_i (grp_pend),
    .ptr_i (pix_ptr),
    .gnt_o (pix_gnt),
    .idx_o (pix_idx),
    .any_o (pix_any)
  );

  assign slot_free = !valid_q || evt_ready_i;

  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    gptr_d     = gptr_q;
    burst_d    = burst_q;
    last_d     = last_q;
    valid_d    = valid_q;
    evt_d      = evt_q;
    clr_mask   = '0;
    rem        = 1'b0;
    burst_next = (state_q == ST_IDLE) ? BW'(1) : burst_q + BW'(1);

    // In IDLE the pixel arbiter already looks at the group the group arbiter chose,
    // so pix_any alone says whether anything can be loaded.
    load = slot_free && pix_any;

    if (slot_free) begin
      valid_d = 1'b0;
    end

    if (load) begin
      valid_d    = 1'b1;
      evt_d.addr = EBC_ADDR_MAX_W'({sel_grp, pix_idx});
      evt_d.ts   = EBC_TS_MAX_W'(ts_now);
      last_d     = pix_idx;
      clr_mask   = NPIX'(pix_gnt) << (int'(sel_grp) * GRP_PIX);
    end

    // Set wins over the served pixel's clear.
    pend_d = (pend_q & ~clr_mask) | set_i;
    rem    = |pend_d[int'(sel_grp)*GRP_PIX +: GRP_PIX];

    if (load) begin
      burst_d = burst_next;
      lock_d  = sel_grp;
      // Releasing on the load edge itself (also from IDLE) keeps the next cycle free
      // to serve another group, so back-to-back events never bubble.
      if (!rem || burst_next == BW'(MAX_BURST)) begin
        state_d = ST_IDLE;
        gptr_d  = sel_grp + GA_W'(1);
      end else begin
        state_d = ST_SERVE;
      end
    end else if (slot_free && state_q == ST_SERVE) begin
      state_d = ST_IDLE;
      gptr_d  = lock_q + GA_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      lock_q  <= '0;
      gptr_q  <= '0;
      burst_q <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      lock_q  <= lock_d;
      gptr_q  <= gptr_d;
      burst_q <= burst_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      evt_q   <= evt_d;
    end
  end

`ifdef EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  assign ts_now   = ts_q;
  assign evt_ts_o = evt_q.ts[TS_W-1:0];
`else
  assign ts_now   = '0;
  assign evt_ts_o = '0;
`endif

  assign evt_unused  = ^evt_q;
  assign evt_valid_o = valid_q;
  assign evt_addr_o  = evt_q.addr[AW-1:0];
  assign pend_o      = pend_q;
  assign busy_o      = valid_q || (|pend_q);

endmodule

// File: tb/tb_event_readout_arbiter.sv
// tb/tb_event_readout_arbiter.sv - directed self-checking bench for event_readout_arbiter
module tb_event_readout_arbiter;

  localparam int NUM_GRP   = 16;
  localparam int GRP_PIX   = 16;
  localparam int MAX_BURST = 4;
  localparam int TS_W      = 4;
  localparam int NPIX      = NUM_GRP * GRP_PIX;

  logic             clk;
  logic             reset;
  logic [NPIX-1:0]  set_i;
  logic             evt_valid_o;
  logic             evt_ready_i;
  logic [7:0]       evt_addr_o;
  logic [TS_W-1:0]  evt_ts_o;
  logic [NPIX-1:0]  pend_o;
  logic             busy_o;

  int total;
  int bad;
  int edges;

  logic [7:0] seq_t2 [7];
  logic [7:0] seq_t4 [9];

  event_readout_arbiter #(
    .NUM_GRP   (NUM_GRP),
    .GRP_PIX   (GRP_PIX),
    .MAX_BURST (MAX_BURST),
    .TS_W      (TS_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .set_i       (set_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_addr_o  (evt_addr_o),
    .evt_ts_o    (evt_ts_o),
    .pend_o      (pend_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NPIX-1:0] obs, input logic [NPIX-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  function automatic logic [NPIX-1:0] bitv(input int i);
    logic [NPIX-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Timestamp captured on the load edge that just happened: counter value before it.
  function automatic logic [TS_W-1:0] exp_ts();
`ifdef EVT_TIMESTAMP_EN
    return TS_W'((edges - 1) % (1 << TS_W));
`else
    return '0;
`endif
  endfunction

  task automatic do_reset();
    reset       = 1'b1;
    set_i       = '0;
    evt_ready_i = 1'b0;
    step();
    step();
    reset = 1'b0;
    edges = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    edges = 0;
    seq_t2 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h52, 8'h04, 8'h05};
    seq_t4 = '{8'h17, 8'h17, 8'h17, 8'h17, 8'h20, 8'h17, 8'h17, 8'h17, 8'h17};

    // Reset state
    do_reset();
    chk("rst_valid", NPIX'(evt_valid_o), '0);
    chk("rst_addr",  NPIX'(evt_addr_o), '0);
    chk("rst_ts",    NPIX'(evt_ts_o), '0);
    chk("rst_pend",  pend_o, '0);
    chk("rst_busy",  NPIX'(busy_o), '0);

    // Single event on bit 37 = {2,5}
    evt_ready_i = 1'b1;
    set_i = bitv(37);
    step();
    set_i = '0;
    chk("t1_pend_set", pend_o, bitv(37));
    chk("t1_no_valid_yet", NPIX'(evt_valid_o), '0);
    chk("t1_busy", NPIX'(busy_o), 1);
    step();
    chk("t1_valid", NPIX'(evt_valid_o), 1);
    chk("t1_addr", NPIX'(evt_addr_o), NPIX'(8'h25));
    chk("t1_pend_clr", pend_o, '0);
    chk("t1_ts", NPIX'(evt_ts_o), NPIX'(exp_ts()));
    step();
    chk("t1_valid_drop", NPIX'(evt_valid_o), 0);
    chk("t1_busy_drop", NPIX'(busy_o), 0);

    // Timestamp after an idle stretch (wraps at 16)
    repeat (20) step();
    set_i = bitv(0);
    step();
    set_i = '0;
    step();
    chk("ts_valid", NPIX'(evt_valid_o), 1);
    chk("ts_addr", NPIX'(evt_addr_o), NPIX'(8'h00));
    chk("ts_value", NPIX'(evt_ts_o), NPIX'(exp_ts()));
    step();

    // Burst limit: group 0 pixels 0..5 plus group 5 pixel 2
    do_reset();
    evt_ready_i = 1'b1;
    set_i = NPIX'(64'h3F) | bitv(5*16+2);
    step();
    set_i = '0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("t2_valid_%0d", i), NPIX'(evt_valid_o), 1);
      chk($sformatf("t2_addr_%0d", i), NPIX'(evt_addr_o), NPIX'(seq_t2[i]));
    end
    step();
    chk("t2_end_valid", NPIX'(evt_valid_o), 0);
    chk("t2_end_pend", pend_o, '0);

    // Stall holds {3,1}; {3,3} follows on the ready edge
    evt_ready_i = 1'b0;
    set_i = bitv(49) | bitv(51);
    step();
    set_i = '0;
    step();
    chk("t3_first", NPIX'(evt_addr_o), NPIX'(8'h31));
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t3_hold_valid_%0d", i), NPIX'(evt_valid_o), 1);
      chk($sformatf("t3_hold_addr_%0d", i), NPIX'(evt_addr_o), NPIX'(8'h31));
    end
    evt_ready_i = 1'b1;
    step();
    chk("t3_next_valid", NPIX'(evt_valid_o), 1);
    chk("t3_next_addr", NPIX'(evt_addr_o), NPIX'(8'h33));
    step();
    chk("t3_done", NPIX'(evt_valid_o), 0);

    // Continuously firing {1,7} interleaved with {2,0}
    set_i = bitv(23) | bitv(32);
    step();
    set_i = bitv(23);
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("t4_addr_%0d", i), NPIX'(evt_addr_o), NPIX'(seq_t4[i]));
      chk($sformatf("t4_latch_%0d", i), NPIX'(pend_o[23]), 1);
    end
    set_i = '0;
    step();
    chk("t4_last_addr", NPIX'(evt_addr_o), NPIX'(8'h17));
    chk("t4_last_pend", pend_o, '0);
    step();
    chk("t4_idle_valid", NPIX'(evt_valid_o), 0);
    chk("t4_idle_busy", NPIX'(busy_o), 0);

    // Reset during a burst of three in group 6
    evt_ready_i = 1'b0;
    set_i = bitv(96) | bitv(97) | bitv(98);
    step();
    set_i = '0;
    step();
    chk("t5_inflight", NPIX'(evt_addr_o), NPIX'(8'h60));
    reset = 1'b1;
    #1;
    chk("t5_async_valid", NPIX'(evt_valid_o), 0);
    chk("t5_async_pend", pend_o, '0);
    step();
    step();
    reset = 1'b0;
    edges = 0;
    evt_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t5_no_stale_%0d", i), NPIX'(evt_valid_o), 0);
      chk($sformatf("t5_no_busy_%0d", i), NPIX'(busy_o), 0);
    end

    // First edge after release samples set_i
    set_i = bitv(200);
    step();
    set_i = '0;
    chk("t6_sampled", pend_o, bitv(200));
    step();
    chk("t6_addr", NPIX'(evt_addr_o), NPIX'(8'hC8));
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
